// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and requester IDs.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for the data-memory arbiter: request handshake plus registered response.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the pointer,
// and each accepted grant hands priority to the other side.
module rr_arbiter2 #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    logic ptr_q, ptr_d;
    logic win;

    always_comb begin
        win = ptr_q;
        if (req_i == 2'b01) win = 1'b0;
        else if (req_i == 2'b10) win = 1'b1;

        grant_o = 2'b00;
        if (|req_i) grant_o[win] = 1'b1;
        grant_id_o = win;

        ptr_d = (advance_i && |req_i) ? ~win : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= PRIO_INIT;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port word memory between two requesters: round-robin accept,
// one access in flight, range/alignment check before issue, registered response.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int   ADDR_W    = 32,
    parameter int   DATA_W    = 32,
    parameter int   MEM_WORDS = 256,
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    // One extra bit so 4*MEM_WORDS is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * MEM_WORDS);

    state_e            state_q, state_d;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [1:0]        req_vec;
    logic [1:0]        grant_vec;
    logic              grant_id;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_write;
    logic              sel_err;

    assign req_vec = {m1.req_valid, m0.req_valid};
    assign accept  = (state_q == ST_IDLE) && (|req_vec) && !reset;

    rr_arbiter2 #(.PRIO_INIT(PRIO_INIT)) u_rr (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_vec),
        .advance_i  (accept),
        .grant_o    (grant_vec),
        .grant_id_o (grant_id)
    );

    assign sel_addr  = (grant_id == REQ_M1) ? m1.req_addr  : m0.req_addr;
    assign sel_wdata = (grant_id == REQ_M1) ? m1.req_wdata : m0.req_wdata;
    assign sel_write = (grant_id == REQ_M1) ? m1.req_write : m0.req_write;
    assign sel_err   = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= ADDR_LIMIT);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d        = state_q;
        m0.req_ready   = accept && grant_vec[0];
        m1.req_ready   = accept && grant_vec[1];
        m0.resp_valid  = 1'b0;
        m1.resp_valid  = 1'b0;
        m0.resp_rdata  = '0;
        m1.resp_rdata  = '0;
        m0.resp_err    = 1'b0;
        m1.resp_err    = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_vec) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_d        = ST_RESP;
                mem_address    = addr_q;
                mem_write_data = wdata_q;
                // Gating with reset keeps a store aborted mid-access out of memory.
                mem_write      = !err_q && write_q && !reset;
                mem_read       = !err_q && !write_q && !reset;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (!reset) begin
                    if (owner_q == REQ_M0) begin
                        m0.resp_valid = 1'b1;
                        m0.resp_rdata = rdata_q;
                        m0.resp_err   = err_q;
                    end else begin
                        m1.resp_valid = 1'b1;
                        m1.resp_rdata = rdata_q;
                        m1.resp_err   = err_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= REQ_M0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= grant_id;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                write_q <= sel_write;
                err_q   <= sel_err;
            end
            if (state_q == ST_ACCESS)
                rdata_q <= (!err_q && !write_q) ? mem_read_data : '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256-word behavioural data memory attached.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic mem_write_seen = 1'b0;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(256), .PRIO_INIT(1'b0)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_if.slave),
        .m1             (m1_if.slave),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    // NOTE: the memory array has no reset; reset clears control state only, never stored data.
    logic [DATA_W-1:0] mem [256] = '{default: '0};
    assign mem_read_data = mem[mem_address[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_write_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_write) mem_write_seen <= 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int who, input logic v, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (who == 0) begin
            m0_if.req_valid = v; m0_if.req_write = wr; m0_if.req_addr = addr; m0_if.req_wdata = wd;
        end else begin
            m1_if.req_valid = v; m1_if.req_write = wr; m1_if.req_addr = addr; m1_if.req_wdata = wd;
        end
    endtask

    function automatic logic ready_of(input int who);
        return (who == 0) ? m0_if.req_ready : m1_if.req_ready;
    endfunction

    function automatic logic rv_of(input int who);
        return (who == 0) ? m0_if.resp_valid : m1_if.resp_valid;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One complete transaction; lat is resp cycle minus accept cycle, -1 on timeout.
    task automatic issue(input int who, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic err, output int lat, output logic other_rv);
        int acc;
        acc = -1; lat = -1; rdata = '0; err = 1'b0; other_rv = 1'b0;
        @(posedge clk); #1;
        drive(who, 1'b1, wr, addr, wd);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready_of(who)) begin acc = cyc; break; end
        end
        @(posedge clk); #1;
        drive(who, 1'b0, 1'b0, '0, '0);
        if (acc < 0) begin
            check("accept_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rv_of(who)) begin
                lat      = cyc - acc;
                rdata    = (who == 0) ? m0_if.resp_rdata : m1_if.resp_rdata;
                err      = (who == 0) ? m0_if.resp_err   : m1_if.resp_err;
                other_rv = rv_of(who == 0 ? 1 : 0);
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        orv;
        int          lat;
        int          g_who [4];
        int          g_cyc [4];
        int          ng;
        logic        both;
        logic        rv_seen;
        logic        seen_ready;

        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_m0_ready", m0_if.req_ready, 0);
        check("rst_m1_resp_valid", m1_if.resp_valid, 0);
        check("rst_m0_resp_rdata", m0_if.resp_rdata, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_address", mem_address, 0);

        // 1. m0 store then load at 0x10
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, orv);
        check("t1_store_lat", lat, 2);
        check("t1_store_err", er, 0);
        check("t1_store_rdata", rd, 0);
        issue(0, 1'b0, 32'h10, 32'h0, rd, er, lat, orv);
        check("t1_load_lat", lat, 2);
        check("t1_load_rdata", rd, 32'hDEADBEEF);
        check("t1_load_err", er, 0);

        // 2. Contention straight after reset: m0, m1, m0, m1 at 3-cycle spacing
        do_reset();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, '0);
        drive(1, 1'b1, 1'b0, 32'h14, '0);
        ng = 0; both = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m0_if.req_ready && m1_if.req_ready) both = 1'b1;
            if (m0_if.req_ready && ng < 4) begin g_who[ng] = 0; g_cyc[ng] = cyc; ng++; end
            else if (m1_if.req_ready && ng < 4) begin g_who[ng] = 1; g_cyc[ng] = cyc; ng++; end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        check("t2_grant_count", ng, 4);
        check("t2_both_ready", both, 0);
        if (ng == 4) begin
            check("t2_g0_who", g_who[0], 0);
            check("t2_g1_who", g_who[1], 1);
            check("t2_g2_who", g_who[2], 0);
            check("t2_g3_who", g_who[3], 1);
            check("t2_g1_spacing", g_cyc[1] - g_cyc[0], 3);
            check("t2_g2_spacing", g_cyc[2] - g_cyc[1], 3);
        end

        // 3. m1 misaligned and out-of-range stores
        @(posedge clk); #1 mem_write_seen = 1'b0;
        issue(1, 1'b1, 32'h0000_0402, 32'hFFFF_FFFF, rd, er, lat, orv);
        check("t3_misal_err", er, 1);
        check("t3_misal_rdata", rd, 0);
        check("t3_misal_lat", lat, 2);
        issue(1, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, rd, er, lat, orv);
        check("t3_oor_err", er, 1);
        check("t3_oor_rdata", rd, 0);
        check("t3_mem_write_seen", mem_write_seen, 0);
        check("t3_word0", mem[0], 0);
        issue(1, 1'b0, 32'h0000_0400, 32'h0, rd, er, lat, orv);
        check("t3_oor_load_err", er, 1);
        check("t3_oor_load_rdata", rd, 0);

        // 4. Reset during ACCESS of an m0 store
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        seen_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_if.req_ready) begin seen_ready = 1'b1; break; end
        end
        check("t4_accepted", seen_ready, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        check("t4_mem_write_gated", mem_write, 0);
        @(posedge clk); #1 reset = 1'b0;
        rv_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (m0_if.resp_valid) rv_seen = 1'b1;
        end
        check("t4_no_resp", rv_seen, 0);
        issue(0, 1'b0, 32'h20, 32'h0, rd, er, lat, orv);
        check("t4_load_rdata", rd, 0);
        check("t4_load_lat", lat, 2);

        // 5. Last word written by m0, read by m1
        issue(0, 1'b1, 32'h3FC, 32'hA5A5A5A5, rd, er, lat, orv);
        check("t5_store_err", er, 0);
        issue(1, 1'b0, 32'h3FC, 32'h0, rd, er, lat, orv);
        check("t5_load_rdata", rd, 32'hA5A5A5A5);
        check("t5_load_err", er, 0);
        check("t5_m0_resp_valid", orv, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
